// File: rtl/uart_pkg.sv
// Shared constants and elaboration-time helpers for the fractional UART baud generator.
package uart_pkg;

    localparam int CNT_WIDTH_DEF = 13;
    localparam int FRAC_BITS_DEF = 3;
    localparam int OSR_DEF       = 16;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Down-counter carries one extra bit so divisor plus carry never overflows.
    function automatic int cnt_width(input int div_width);
        return div_width + 1;
    endfunction

    function automatic int frac_width(input int frac_bits);
        return (frac_bits > 0) ? frac_bits : 1;
    endfunction

endpackage

// File: rtl/uart_frac_accum.sv
// First-order fractional accumulator: carry stretches the current baud period by one clk.
module uart_frac_accum
#(
    parameter int FRAC_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 restart,
    input  logic [FRAC_BITS-1:0] frac,
    output logic                 carry
);

    logic [FRAC_BITS-1:0] acc_q, acc_d;
    logic [FRAC_BITS:0]   sum;

    assign sum   = {1'b0, acc_q} + {1'b0, frac};
    assign carry = sum[FRAC_BITS];

    always_comb begin
        acc_d = acc_q;
        if (restart) begin
            acc_d = '0;
        end else if (tick) begin
            acc_d = sum[FRAC_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Oversampled UART baud tick generator with fractional divisor, shadowed reconfiguration
// and phase restart.
module uart_baud_gen_frac
    import uart_pkg::*;
#(
    parameter  int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter  int FRAC_BITS = FRAC_BITS_DEF,
    parameter  int OSR       = OSR_DEF,
    localparam int FRAC_W    = frac_width(FRAC_BITS),
    localparam int PHASE_W   = clog2(OSR)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] baud_val,
    input  logic [FRAC_W-1:0]    baud_frac,
    input  logic                 cfg_load,
    input  logic                 tx_restart,
    output logic                 cfg_pending,
    output logic                 baud_clock,
    output logic                 xmit_pulse,
    output logic [PHASE_W-1:0]   osr_phase
);

    localparam int CNT_W = cnt_width(CNT_WIDTH);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] div_app_q, div_app_d;
    logic [CNT_WIDTH-1:0] div_shd_q, div_shd_d;
    logic [FRAC_W-1:0]    frac_app_q, frac_app_d;
    logic [FRAC_W-1:0]    frac_shd_q, frac_shd_d;
    logic                 pend_q, pend_d;
    logic                 baud_q, baud_d;
    logic                 xmit_q, xmit_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;

    logic [CNT_WIDTH-1:0] div_eff;
    logic [FRAC_W-1:0]    frac_eff;
    logic [CNT_W-1:0]     reload;
    logic                 tick;
    logic                 carry;

    // Pending shadow values take effect only at a period boundary (tick or restart).
    assign div_eff  = pend_q ? div_shd_q  : div_app_q;
    assign frac_eff = pend_q ? frac_shd_q : frac_app_q;
    assign tick     = enable && !tx_restart && (cnt_q == '0);
    assign reload   = {1'b0, div_eff} + {{CNT_WIDTH{1'b0}}, carry};

    generate
        if (FRAC_BITS > 0) begin : g_frac
            uart_frac_accum #(
                .FRAC_BITS (FRAC_BITS)
            ) u_accum (
                .clk     (clk),
                .reset   (reset),
                .tick    (tick),
                .restart (tx_restart),
                .frac    (frac_eff),
                .carry   (carry)
            );
        end else begin : g_no_frac
            assign carry = 1'b0;
        end
    endgenerate

    always_comb begin
        cnt_d      = cnt_q;
        div_app_d  = div_app_q;
        div_shd_d  = div_shd_q;
        frac_app_d = frac_app_q;
        frac_shd_d = frac_shd_q;
        pend_d     = pend_q;
        phase_d    = phase_q;
        baud_d     = 1'b0;
        xmit_d     = 1'b0;

        if (tx_restart) begin
            cnt_d   = {1'b0, div_eff};
            phase_d = '0;
        end else if (enable) begin
            if (cnt_q == '0) begin
                baud_d  = 1'b1;
                cnt_d   = reload;
                phase_d = phase_q + 1'b1;
                xmit_d  = (phase_q == PHASE_W'(OSR - 1));
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        if (pend_q && (tick || tx_restart)) begin
            div_app_d  = div_shd_q;
            frac_app_d = frac_shd_q;
            pend_d     = 1'b0;
        end

        // A load that lands on a tick edge is deferred to the following tick;
        // while frozen there is no period to protect, so it applies at once.
        if (cfg_load) begin
            div_shd_d  = baud_val;
            frac_shd_d = baud_frac;
            if (enable) begin
                pend_d = 1'b1;
            end else begin
                div_app_d  = baud_val;
                frac_app_d = baud_frac;
                pend_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            div_app_q  <= '0;
            div_shd_q  <= '0;
            frac_app_q <= '0;
            frac_shd_q <= '0;
            pend_q     <= 1'b0;
            baud_q     <= 1'b0;
            xmit_q     <= 1'b0;
            phase_q    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            div_app_q  <= div_app_d;
            div_shd_q  <= div_shd_d;
            frac_app_q <= frac_app_d;
            frac_shd_q <= frac_shd_d;
            pend_q     <= pend_d;
            baud_q     <= baud_d;
            xmit_q     <= xmit_d;
            phase_q    <= phase_d;
        end
    end

    assign cfg_pending = pend_q;
    assign baud_clock  = baud_q;
    assign xmit_pulse  = xmit_q;
    assign osr_phase   = phase_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Directed bench for uart_baud_gen_frac: vector table of divisor settings plus
// hand-written sequences for reload, freeze, restart and reset corner cases.
module tb_uart_baud_gen_frac;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [12:0] baud_val;
    logic [2:0]  baud_frac;
    logic        cfg_load;
    logic        tx_restart;
    logic        cfg_pending;
    logic        baud_clock;
    logic        xmit_pulse;
    logic [3:0]  osr_phase;

    int cyc;
    int n_pass;
    int n_total;

    uart_baud_gen_frac dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .baud_val    (baud_val),
        .baud_frac   (baud_frac),
        .cfg_load    (cfg_load),
        .tx_restart  (tx_restart),
        .cfg_pending (cfg_pending),
        .baud_clock  (baud_clock),
        .xmit_pulse  (xmit_pulse),
        .osr_phase   (osr_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int bv;
        int fr;
        int n;
        int exp_span;
        int exp_long;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input int bound, output int t);
        bit seen;
        seen = 1'b0;
        t    = cyc;
        for (int i = 0; i < bound && !seen; i++) begin
            step();
            if (baud_clock) begin
                seen = 1'b1;
                t    = cyc;
            end
        end
        if (!seen) chk("tick_timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        enable     = 1'b0;
        cfg_load   = 1'b0;
        tx_restart = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic configure(input int bv, input int fr);
        enable    = 1'b0;
        baud_val  = 13'(bv);
        baud_frac = 3'(fr);
        cfg_load  = 1'b1;
        step();
        cfg_load = 1'b0;
    endtask

    initial begin
        int t0, t1, t2, t3, t4, tc, t_en, t_x, t_r;
        int span, longs, prev, per, ticks, nx, highs, psum;

        n_pass = 0;
        n_total = 0;
        reset = 1'b1; enable = 1'b0; cfg_load = 1'b0; tx_restart = 1'b0;
        baud_val = '0; baud_frac = '0;

        vecs[0] = '{bv: 3,    fr: 0, n: 8, exp_span: 32,    exp_long: 0};
        vecs[1] = '{bv: 3,    fr: 4, n: 8, exp_span: 36,    exp_long: 4};
        vecs[2] = '{bv: 3,    fr: 1, n: 8, exp_span: 33,    exp_long: 1};
        vecs[3] = '{bv: 5,    fr: 3, n: 8, exp_span: 51,    exp_long: 3};
        vecs[4] = '{bv: 0,    fr: 0, n: 8, exp_span: 8,     exp_long: 0};
        vecs[5] = '{bv: 0,    fr: 7, n: 8, exp_span: 15,    exp_long: 7};
        vecs[6] = '{bv: 8191, fr: 7, n: 2, exp_span: 16385, exp_long: 1};

        // Reset state
        do_reset();
        reset = 1'b1;
        step();
        chk("rst_baud_clock", baud_clock, 0);
        chk("rst_xmit_pulse", xmit_pulse, 0);
        chk("rst_cfg_pending", cfg_pending, 0);
        chk("rst_osr_phase", osr_phase, 0);
        reset = 1'b0;

        // Table-driven period / fraction vectors
        for (int v = 0; v < 7; v++) begin
            do_reset();
            configure(vecs[v].bv, vecs[v].fr);
            chk("vec_load_idle_pending", cfg_pending, 0);
            enable = 1'b1;
            t_en = cyc;
            wait_tick(5, t0);
            chk("vec_first_tick_latency", t0 - t_en, 1);
            prev = t0;
            longs = 0;
            for (int k = 0; k < vecs[v].n; k++) begin
                wait_tick(vecs[v].bv + 10, t1);
                per = t1 - prev;
                if (per == vecs[v].bv + 2) longs++;
                prev = t1;
            end
            span = prev - t0;
            chk("vec_span", span, vecs[v].exp_span);
            chk("vec_long_periods", longs, vecs[v].exp_long);
            $display("vec %0d: baud_val=%0d frac=%0d span=%0d long=%0d",
                     v, vecs[v].bv, vecs[v].fr, span, longs);
        end

        // xmit_pulse placement: 16th tick, then every 64 clks
        do_reset();
        configure(3, 0);
        enable = 1'b1;
        t_en = cyc;
        ticks = 0;
        nx = 0;
        t_x = cyc;
        for (int i = 0; i < 140 && nx < 2; i++) begin
            step();
            if (baud_clock) ticks++;
            if (xmit_pulse) begin
                if (nx == 0) begin
                    chk("xmit_first_time", cyc - t_en, 61);
                    chk("xmit_first_tick_idx", ticks, 16);
                    chk("xmit_with_baud", baud_clock, 1);
                    chk("xmit_phase_wrap", osr_phase, 0);
                    t_x = cyc;
                end else begin
                    chk("xmit_spacing", cyc - t_x, 64);
                end
                nx++;
            end
        end
        chk("xmit_count", nx, 2);
        $display("xmit: first at +%0d clks after enable", t_x - t_en);

        // Mid-period reload 3 -> 7, then tick-coincident reload 7 -> 3
        do_reset();
        configure(3, 0);
        enable = 1'b1;
        wait_tick(5, t0);
        step();
        baud_val = 13'd7;
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
        chk("reload_pending_set", cfg_pending, 1);
        wait_tick(10, t1);
        chk("reload_old_period", t1 - t0, 4);
        chk("reload_pending_clear", cfg_pending, 0);
        wait_tick(12, t2);
        chk("reload_new_period", t2 - t1, 8);
        for (int i = 0; i < 7; i++) step();
        baud_val = 13'd3;
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
        tc = cyc;
        chk("coinc_tick", baud_clock, 1);
        chk("coinc_pending_set", cfg_pending, 1);
        wait_tick(12, t3);
        chk("coinc_old_period", t3 - tc, 8);
        chk("coinc_pending_clear", cfg_pending, 0);
        wait_tick(10, t4);
        chk("coinc_new_period", t4 - t3, 4);
        $display("reload: periods %0d %0d %0d %0d", t1 - t0, t2 - t1, t3 - tc, t4 - t3);

        // Enable freeze at cnt=1
        do_reset();
        configure(3, 0);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) wait_tick(10, t0);
        step();
        step();
        enable = 1'b0;
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (baud_clock || xmit_pulse) highs++;
        end
        chk("freeze_no_pulses", highs, 0);
        chk("freeze_phase_held", osr_phase, 3);
        enable = 1'b1;
        t_en = cyc;
        wait_tick(10, t1);
        chk("freeze_resume_latency", t1 - t_en, 2);
        chk("freeze_resume_phase", osr_phase, 4);
        $display("freeze: resumed tick after %0d clks", t1 - t_en);

        // tx_restart at osr_phase=9 with baud_val=5, frac=3
        do_reset();
        configure(5, 3);
        enable = 1'b1;
        for (int i = 0; i < 20 && osr_phase != 4'd9; i++) wait_tick(10, t0);
        chk("restart_reach_phase9", osr_phase, 9);
        step();
        step();
        tx_restart = 1'b1;
        step();
        tx_restart = 1'b0;
        t_r = cyc;
        chk("restart_phase_zero", osr_phase, 0);
        chk("restart_baud_low", baud_clock, 0);
        wait_tick(12, t1);
        chk("restart_first_period", t1 - t_r, 6);
        ticks = 1;
        prev = t1;
        psum = 0;
        nx = xmit_pulse ? 1 : 0;
        for (int i = 0; i < 20 && nx == 0; i++) begin
            wait_tick(12, t2);
            ticks++;
            if (ticks <= 4) psum += t2 - prev;
            prev = t2;
            if (xmit_pulse) nx = 1;
        end
        chk("restart_acc_cleared", psum, 19);
        chk("restart_xmit_tick", ticks, 16);
        $display("restart: first tick +%0d, xmit on tick %0d", t1 - t_r, ticks);

        // baud_val=0, frac=0: constant baud_clock, xmit every 16
        do_reset();
        configure(0, 0);
        enable = 1'b1;
        t_en = cyc;
        highs = 0;
        nx = 0;
        t_x = cyc;
        for (int i = 0; i < 40; i++) begin
            step();
            if (baud_clock) highs++;
            if (xmit_pulse) begin
                if (nx == 0) chk("div0_first_xmit", cyc - t_en, 16);
                else chk("div0_xmit_spacing", cyc - t_x, 16);
                t_x = cyc;
                nx++;
            end
        end
        chk("div0_baud_const", highs, 40);
        chk("div0_xmit_count", nx, 2);
        $display("div0: %0d ticks, %0d xmit pulses in 40 clks", highs, nx);

        // Reset during a run, colliding with a cfg_load
        chk("midrst_pre_baud", baud_clock, 1);
        baud_val = 13'd3;
        cfg_load = 1'b1;
        reset = 1'b1;
        step();
        cfg_load = 1'b0;
        chk("midrst_baud", baud_clock, 0);
        chk("midrst_xmit", xmit_pulse, 0);
        chk("midrst_pending", cfg_pending, 0);
        chk("midrst_phase", osr_phase, 0);
        reset = 1'b0;
        $display("midrst: outputs cleared at cycle %0d", cyc);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_baud_gen_frac.md
Name: uart_baud_gen_frac

Overview:
Parametrised successor to the fixed 13-bit/x16 UART baud generator. Produces an oversampled baud tick and a once-per-bit transmit pulse, with the following generalisations:
- configurable counter width, oversample ratio and fractional resolution;
- a first-order accumulator fractional divider instead of fixed per-fraction decode tables;
- glitch-free runtime reconfiguration;
- clock enable and synchronous phase restart.

Sits between the register/APB interface and the UART tx/rx engines.

Parameters:
CNT_WIDTH, 13, width of integer divisor baud_val (2..16)
FRAC_BITS, 3, width of fractional divisor; resolution 1/2^FRAC_BITS (0..6; 0 disables fractional logic)
OSR, 16, baud ticks per bit; power of two, 4..16

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  count enable; low freezes all state
baud_val  input  CNT_WIDTH  integer divisor; tick period = baud_val+1 clk
baud_frac  input  max(FRAC_BITS,1)  fractional divisor numerator
cfg_load  input  1  one-cycle strobe; captures baud_val/baud_frac into shadow registers
tx_restart  input  1  synchronous phase realign (e.g. start-bit detect)
cfg_pending  output  1  shadow values captured but not yet applied
baud_clock  output  1  one-clk oversample tick
xmit_pulse  output  1  one-clk pulse coincident with every OSR-th baud_clock
osr_phase  output  clog2(OSR)  current tick index within bit period

Behaviour:
- All outputs registered. Reset values: baud_clock=0, xmit_pulse=0, cfg_pending=0, osr_phase=0.
- State reset values: cnt=0, acc=0, applied/shadow divisors=0.
- Priority at each edge: reset > tx_restart > enable=0 > normal count.
- Normal count (enable=1):
  - If cnt==0, the edge is a tick: baud_clock<=1 and cnt<=reload.
  - Otherwise cnt<=cnt-1 and baud_clock<=0.
- Fraction:
  - At each tick, {carry,acc}<=acc+frac_eff.
  - reload = div_eff + carry, computed CNT_WIDTH+1 bits wide; cnt is CNT_WIDTH+1 bits, so there is no overflow at baud_val all-ones.
  - Over any 2^FRAC_BITS consecutive ticks, exactly baud_frac periods are extended by one clk.
  - Mean period = baud_val+1+baud_frac/2^FRAC_BITS.
- div_eff/frac_eff: if cfg_pending=1 at a tick edge, use the shadow values, copy them into the applied registers, and clear cfg_pending. Otherwise use the applied values.
- Reconfiguration is therefore glitch-free: a partial period never mixes old and new divisors.
- cfg_load:
  - Sets shadow and cfg_pending=1. A repeated load while pending overwrites the shadow; the latest load wins.
  - cfg_load on the same edge as a tick: that tick uses the previous pending/applied values; the new values apply at the following tick.
  - cfg_load while enable=0: the values are applied on the next edge (immediate) and cfg_pending stays 0.
- OSR phase:
  - At each tick edge: osr_phase<=osr_phase+1 (wraps modulo OSR).
  - xmit_pulse<=1 iff osr_phase==OSR-1 at that edge; otherwise 0.
  - The first xmit_pulse after reset is coincident with the OSR-th baud_clock.
- enable=0: cnt, acc, osr_phase and cfg state hold; baud_clock and xmit_pulse go to 0 on the next edge. Counting resumes from the held cnt.
- tx_restart:
  - Effects: cnt<=applied-or-pending divisor, pending applied, acc<=0, osr_phase<=0, baud_clock<=0, xmit_pulse<=0.
  - Result: the next tick comes divisor+1 clks later, with no extension.
- baud_val=0, baud_frac=0: baud_clock is high every cycle once running.
- reset mid-bit aborts immediately; no partial pulse is emitted.

Decomposition:
- Package uart_pkg:
  - constants CNT_WIDTH_DEF=13, FRAC_BITS_DEF=3, OSR_DEF=16;
  - function clog2;
  - typedef-style localparams for the cnt width (CNT_WIDTH+1) and the phase width.
- One natural sub-module: uart_frac_accum. It holds the accumulator register and produces carry, with clk, reset, tick, restart and frac inputs. It is generated away when FRAC_BITS=0.

Test Plan:
- CNT_WIDTH=13, OSR=16, baud_val=3, frac=0 -> baud_clock every 4 clks; xmit_pulse every 64 clks; first baud_clock 1 clk after reset release.
- baud_val=3, FRAC_BITS=3, frac=4 -> periods 4,5,4,5…; 8 ticks span exactly 36 clks.
- frac=1 -> 8 ticks span 33 clks, with exactly one 5-clk period.
- cfg_load baud_val=7 mid-period (cnt=2 of divisor 3):
  - cfg_pending=1;
  - current period completes at 4 clks;
  - the next period is 8 clks;
  - cfg_pending clears at that tick.
- enable low for 10 clks at cnt=1 -> no baud_clock/xmit_pulse during that time; after re-enable the next tick arrives 2 clks later; osr_phase unchanged.
- tx_restart at osr_phase=9, baud_val=5, frac=3 -> osr_phase=0, acc=0; next tick 6 clks later; xmit_pulse 16 ticks after the restart.
- baud_val=0, frac=0 -> baud_clock constant high; xmit_pulse every 16 clks.
- Assert reset during a run -> all outputs 0 on the next edge.
